csa_accum_ctrl: RTL and testbench
=================================

// Module: csa_accum_ctrl
// PURPOSE
//  Sequences a shared 4:2 compressor as a multi-beat carry-save accumulator.
//  Each accepted beat supplies two signed operands. The compressor reduces
//  {op_a, op_b, acc_sum, acc_carry} into a new sum/carry pair every cycle.
//  After the last beat, one carry-propagate add resolves the result, which is
//  then offered on a valid/ready port. Sits between partial-product sources
//  (MAC / dot-product lanes) and the AI core result path.
// PARAMETERS
//  IN_SIZE   14  width of each signed input operand
//  ACC_SIZE  24  width of the accumulator and result, two's complement
//  CNT_W     8   width of the beat counter
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_ni       in   1         reset, asynchronous, active-low
//  clear_i      in   1         synchronous abort: drop the group, return to ACCUM
//  in_valid_i   in   1         operand beat valid
//  in_ready_o   out  1         beat accepted when in_valid_i && in_ready_o
//  in_a_i       in   IN_SIZE   signed operand A
//  in_b_i       in   IN_SIZE   signed operand B
//  in_last_i    in   1         beat is the final beat of the group
//  res_valid_o  out  1         result valid
//  res_ready_i  in   1         result consumed when res_valid_o && res_ready_i
//  res_o        out  ACC_SIZE  resolved sum of all operands, modulo 2^ACC_SIZE
//  res_beats_o  out  CNT_W     number of beats in the group, saturating
//  busy_o       out  1         high in RESOLVE/DONE, or in ACCUM once beat count != 0
// BEHAVIOUR
//  - Reset: state=ACCUM; acc_sum, acc_carry, res_o, count = 0;
//    res_valid_o=0; in_ready_o=1; busy_o=0.
//  - Datapath: operands are sign-extended to ACC_SIZE. The compressor is
//    instantiated with IN_SIZE=ACC_SIZE, OUT_SIZE=ACC_SIZE+1, and its outputs
//    are truncated to ACC_SIZE bits, so all arithmetic wraps modulo 2^ACC_SIZE.
//  - The compressor sum/carry are registered into acc_sum/acc_carry only on an
//    accepted beat. Otherwise the accumulators hold.
//  - ACCUM:
//    - in_ready_o = !clear_i.
//    - Accepted beat: update acc, count = sat(count+1).
//    - Accepted beat with in_last_i=1: go to RESOLVE.
//    - in_valid_i=0 bubbles are allowed and change nothing.
//  - RESOLVE (exactly 1 cycle): in_ready_o=0.
//    - res_o <= acc_sum + acc_carry, truncated to ACC_SIZE.
//    - res_beats_o <= count.
//    - Go to DONE.
//  - DONE: res_valid_o=1, in_ready_o=0.
//    - res_o and res_beats_o stay stable until the handshake.
//    - On res_ready_i=1: clear acc and count, res_valid_o=0 next cycle, go to
//      ACCUM. The next beat is accepted no earlier than the following cycle.
//  - Latency: last beat accepted at cycle T -> res_valid_o=1 at T+2.
//    Zero-bubble throughput is therefore N+2 cycles per N-beat group, plus
//    the result wait.
//  - Single-beat group (first beat has last=1): the result is in_a_i+in_b_i.
//  - count saturates at 2^CNT_W-1. Accumulation continues correctly beyond
//    saturation; only res_beats_o saturates.
//  - Overflow beyond ACC_SIZE wraps silently. No flag is raised.
//  - clear_i=1 in any state (highest priority):
//    - Next cycle: state=ACCUM, acc and count = 0, res_valid_o=0.
//    - A beat presented in the same cycle is NOT accepted (in_ready_o=0).
//    - A pending result is discarded, even if res_ready_i=1 in that cycle.
//  - Reset asserted mid-group: outputs go to their reset values immediately
//    (asynchronous) and the partial group is lost.
//  - res_o and res_beats_o are don't-care when res_valid_o=0, but must be
//    deterministic; they hold their last value.
// TESTING
//  - Reset, then 3 beats (a,b) = (1,2),(3,4),(5,6), last on the 3rd, res_ready=1
//    -> res_valid at T+2, res_o=21, res_beats_o=3, then in_ready=1 again.
//  - Signed values: beats (-8192,-1),(100,-50), last
//    -> res_o = -8143 sign-extended in ACC_SIZE, res_beats_o=2.
//  - Single beat (8191,8191), last; res_ready held low 5 cycles
//    -> res_o=16382 stable for all 5 cycles, in_ready=0 throughout; accepted
//    on the 6th cycle.
//  - Random in_valid bubbles in a 10-beat group of (i,-i) for i=1..10
//    -> res_o=0, res_beats_o=10; acc unchanged on bubble cycles.
//  - clear_i pulsed with in_valid=1 during a group, and again in DONE
//    -> that beat is not accepted, no result is produced, and the next group's
//    result is independent of the aborted data.
//  - Wrap/saturation (CNT_W=4): 20 beats of (2^13-1, 2^13-1)
//    -> res_beats_o=15, res_o=(20*16382) mod 2^ACC_SIZE;
//    rst_ni pulsed mid-group -> all outputs reset asynchronously.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// Multi-beat carry-save accumulator controller.
// Each accepted beat folds two signed operands into a sum/carry pair through a
// shared 4:2 compressor. After the last beat a single carry-propagate add
// resolves the group total, which is then held on a valid/ready result port.

// 4:2 compressor built from two full-adder layers.
// The identity sum + carry == x0 + x1 + x2 + x3 holds modulo 2^OUT_SIZE.
// It is meant to be used with OUT_SIZE == IN_SIZE + 1.
module csa_compress_4to2 #(
  parameter int IN_SIZE  = 24,
  parameter int OUT_SIZE = 25
) (
  input  logic [IN_SIZE-1:0]  x0,
  input  logic [IN_SIZE-1:0]  x1,
  input  logic [IN_SIZE-1:0]  x2,
  input  logic [IN_SIZE-1:0]  x3,
  output logic [OUT_SIZE-1:0] sum,
  output logic [OUT_SIZE-1:0] carry
);

  logic [IN_SIZE-1:0]  s1_s;
  logic [IN_SIZE-1:0]  maj1_s;
  logic [OUT_SIZE-1:0] s1_ext_s;
  logic [OUT_SIZE-1:0] x3_ext_s;
  logic [OUT_SIZE-1:0] c1_s;
  logic [OUT_SIZE-2:0] maj2_s;

  // First layer: reduce x0, x1, x2 to a sum vector and a shifted carry vector.
  assign s1_s   = x0 ^ x1 ^ x2;
  assign maj1_s = (x0 & x1) | (x0 & x2) | (x1 & x2);
  assign c1_s   = {maj1_s, 1'b0};

  // Second layer: fold x3 in together with the first-layer outputs.
  assign s1_ext_s = OUT_SIZE'(s1_s);
  assign x3_ext_s = OUT_SIZE'(x3);
  assign sum      = s1_ext_s ^ x3_ext_s ^ c1_s;
  assign maj2_s   = (s1_ext_s[OUT_SIZE-2:0] & x3_ext_s[OUT_SIZE-2:0])
                  | (s1_ext_s[OUT_SIZE-2:0] & c1_s[OUT_SIZE-2:0])
                  | (x3_ext_s[OUT_SIZE-2:0] & c1_s[OUT_SIZE-2:0]);
  assign carry    = {maj2_s, 1'b0};

endmodule

module csa_accum_ctrl #(
  parameter int IN_SIZE  = 14,
  parameter int ACC_SIZE = 24,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_a_i,
  input  logic [IN_SIZE-1:0]  in_b_i,
  input  logic                in_last_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [ACC_SIZE-1:0] res_o,
  output logic [CNT_W-1:0]    res_beats_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ACC_SIZE-1:0] ACC_ZERO = {ACC_SIZE{1'b0}};

  // Beat counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t              state_r;
  logic [ACC_SIZE-1:0] acc_sum_r;
  logic [ACC_SIZE-1:0] acc_carry_r;
  logic [CNT_W-1:0]    count_r;
  logic [ACC_SIZE-1:0] res_r;
  logic [CNT_W-1:0]    res_beats_r;
  logic                res_valid_r;

  logic [ACC_SIZE-1:0] op_a_s;
  logic [ACC_SIZE-1:0] op_b_s;
  logic [ACC_SIZE:0]   cmp_sum_s;
  logic [ACC_SIZE:0]   cmp_carry_s;
  logic                in_ready_s;
  logic                beat_acc_s;
  logic                busy_s;
  logic                unused_top_s;

  // Operands enter the accumulator domain sign-extended.
  assign op_a_s = {{(ACC_SIZE-IN_SIZE){in_a_i[IN_SIZE-1]}}, in_a_i};
  assign op_b_s = {{(ACC_SIZE-IN_SIZE){in_b_i[IN_SIZE-1]}}, in_b_i};

  csa_compress_4to2 #(
    .IN_SIZE  (ACC_SIZE),
    .OUT_SIZE (ACC_SIZE + 1)
  ) u_compress (
    .x0    (op_a_s),
    .x1    (op_b_s),
    .x2    (acc_sum_r),
    .x3    (acc_carry_r),
    .sum   (cmp_sum_s),
    .carry (cmp_carry_s)
  );

  // Bit ACC_SIZE has weight 2^ACC_SIZE and vanishes under modulo arithmetic.
  assign unused_top_s = cmp_sum_s[ACC_SIZE] ^ cmp_carry_s[ACC_SIZE];

  // Beats are only taken while collecting, and never in a clear cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == ST_ACCUM) begin
      in_ready_s = !clear_i;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign beat_acc_s = in_valid_i & in_ready_s;
  assign busy_s     = (state_r != ST_ACCUM) || (count_r != CNT_ZERO);

  // Control FSM with the accumulator, counter and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_ACCUM;
      acc_sum_r   <= ACC_ZERO;
      acc_carry_r <= ACC_ZERO;
      count_r     <= CNT_ZERO;
      res_r       <= ACC_ZERO;
      res_beats_r <= CNT_ZERO;
      res_valid_r <= 1'b0;
    end else if (clear_i) begin
      // Abort wins over everything; the last result value is simply held.
      state_r     <= ST_ACCUM;
      acc_sum_r   <= ACC_ZERO;
      acc_carry_r <= ACC_ZERO;
      count_r     <= CNT_ZERO;
      res_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (beat_acc_s) begin
            acc_sum_r   <= cmp_sum_s[ACC_SIZE-1:0];
            acc_carry_r <= cmp_carry_s[ACC_SIZE-1:0];
            count_r     <= sat_inc(count_r);
            if (in_last_i) begin
              state_r <= ST_RESOLVE;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_RESOLVE: begin
          res_r       <= acc_sum_r + acc_carry_r;
          res_beats_r <= count_r;
          res_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready_i) begin
            acc_sum_r   <= ACC_ZERO;
            acc_carry_r <= ACC_ZERO;
            count_r     <= CNT_ZERO;
            res_valid_r <= 1'b0;
            state_r     <= ST_ACCUM;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          acc_sum_r   <= ACC_ZERO;
          acc_carry_r <= ACC_ZERO;
          count_r     <= CNT_ZERO;
          res_valid_r <= 1'b0;
          state_r     <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign res_valid_o = res_valid_r;
  assign res_o       = res_r;
  assign res_beats_o = res_beats_r;
  assign busy_o      = busy_s;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: directed groups with hand-computed
// results plus a long randomized run against a behavioural model.
module tb_csa_accum_ctrl;

  localparam int IN_SIZE  = 14;
  localparam int ACC_SIZE = 24;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_SIZE-1:0]  in_a = '0;
  logic [IN_SIZE-1:0]  in_b = '0;
  logic                in_last = 1'b0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [ACC_SIZE-1:0] res;
  logic [CNT_W-1:0]    res_beats;
  logic                busy;

  always #5 clk = ~clk;

  csa_accum_ctrl #(
    .IN_SIZE  (IN_SIZE),
    .ACC_SIZE (ACC_SIZE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_last_i   (in_last),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res),
    .res_beats_o (res_beats),
    .busy_o      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: running integer total, beat tally and a group phase
  // (0 = collecting, 1 = resolving, 2 = result offered).
  longint m_sum;
  int     m_beats;
  int     m_phase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum   <= 0;
      m_beats <= 0;
      m_phase <= 0;
    end else if (clear) begin
      m_sum   <= 0;
      m_beats <= 0;
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_sum   <= m_sum + longint'($signed(in_a)) + longint'($signed(in_b));
        m_beats <= m_beats + 1;
        if (in_last) m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (res_ready) begin
      m_sum   <= 0;
      m_beats <= 0;
      m_phase <= 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      chk("in_ready", 64'(in_ready), 64'((m_phase == 0) && !clear));
      chk("res_valid", 64'(res_valid), 64'(m_phase == 2));
      chk("busy", 64'(busy), 64'((m_phase != 0) || (m_beats != 0)));
      if (m_phase == 2) begin
        chk("res_o", 64'(res), 64'(m_sum[ACC_SIZE-1:0]));
        chk("res_beats", 64'(res_beats), 64'((m_beats > CNT_MAX) ? CNT_MAX : m_beats));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one beat and hold it until taken (bounded).
  task automatic beat(input int a, input int b, input bit last);
    int waited = 0;
    in_a = IN_SIZE'(a);
    in_b = IN_SIZE'(b);
    in_last = last;
    in_valid = 1'b1;
    at_neg();
    while (!in_ready && waited < 50) begin
      tick();
      at_neg();
      waited++;
    end
    chk("beat_accept", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Wait (bounded) until the result is offered; returns at the negedge.
  task automatic wait_done;
    int waited = 0;
    at_neg();
    while (!res_valid && waited < 50) begin
      tick();
      at_neg();
      waited++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'(1));
  endtask

  task automatic consume;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;

    // Reset values
    at_neg();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res_o", 64'(res), 64'(0));
    chk("rst_res_beats", 64'(res_beats), 64'(0));
    tick();

    // Three beats, result two cycles after the last one
    beat(1, 2, 1'b0);
    beat(3, 4, 1'b0);
    beat(5, 6, 1'b1);
    at_neg();
    chk("t1_valid_at_T1", 64'(res_valid), 64'(0));
    tick();
    at_neg();
    chk("t1_valid_at_T2", 64'(res_valid), 64'(1));
    chk("t1_res", 64'(res), 64'(21));
    chk("t1_beats", 64'(res_beats), 64'(3));
    tick();
    consume();
    at_neg();
    chk("t1_ready_again", 64'(in_ready), 64'(1));
    chk("t1_valid_clr", 64'(res_valid), 64'(0));
    tick();

    // Signed operands
    beat(-8192, -1, 1'b0);
    beat(100, -50, 1'b1);
    wait_done();
    chk("t2_res", 64'(res), 64'(24'hFFE031));
    chk("t2_beats", 64'(res_beats), 64'(2));
    tick();
    consume();

    // Single beat with a stalled consumer
    beat(8191, 8191, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t3_res_stable", 64'(res), 64'(16382));
      chk("t3_in_ready_low", 64'(in_ready), 64'(0));
      tick();
    end
    consume();
    at_neg();
    chk("t3_consumed", 64'(res_valid), 64'(0));
    tick();

    // Ten beats (i,-i) with random bubbles
    for (int i = 1; i <= 10; i++) begin
      beat(i, -i, i == 10);
      if (i < 10) idle(int'($urandom_range(0, 3)));
    end
    wait_done();
    chk("t4_res", 64'(res), 64'(0));
    chk("t4_beats", 64'(res_beats), 64'(10));
    tick();
    consume();

    // Clear during a group, with a beat presented in the clear cycle
    beat(100, 200, 1'b0);
    beat(300, 400, 1'b0);
    in_a = IN_SIZE'(999);
    in_b = IN_SIZE'(999);
    in_valid = 1'b1;
    clear = 1'b1;
    at_neg();
    chk("t5_clr_not_ready", 64'(in_ready), 64'(0));
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    at_neg();
    chk("t5_clr_busy", 64'(busy), 64'(0));
    chk("t5_clr_no_result", 64'(res_valid), 64'(0));
    tick();
    idle(3);
    beat(7, 8, 1'b1);
    wait_done();
    chk("t5_fresh_res", 64'(res), 64'(15));
    chk("t5_fresh_beats", 64'(res_beats), 64'(1));
    tick();
    consume();

    // Clear in DONE beats a simultaneous res_ready
    beat(50, 60, 1'b1);
    wait_done();
    tick();
    clear = 1'b1;
    res_ready = 1'b1;
    tick();
    clear = 1'b0;
    res_ready = 1'b0;
    at_neg();
    chk("t5_done_clr_valid", 64'(res_valid), 64'(0));
    chk("t5_done_clr_busy", 64'(busy), 64'(0));
    chk("t5_done_clr_ready", 64'(in_ready), 64'(1));
    tick();
    beat(1, 1, 1'b1);
    wait_done();
    chk("t5_after_clr_res", 64'(res), 64'(2));
    tick();
    consume();

    // Counter saturation
    for (int i = 1; i <= 20; i++) beat(8191, 8191, i == 20);
    wait_done();
    chk("t6_sat_beats", 64'(res_beats), 64'(15));
    chk("t6_sat_res", 64'(res), 64'(327640));
    tick();
    consume();

    // Accumulator wrap: 1100 * 16382 mod 2^24
    for (int i = 1; i <= 1100; i++) beat(8191, 8191, i == 1100);
    wait_done();
    chk("t6_wrap_res", 64'(res), 64'(1242984));
    chk("t6_wrap_beats", 64'(res_beats), 64'(15));
    tick();
    consume();

    // Asynchronous reset mid-group
    beat(5, 5, 1'b0);
    beat(5, 5, 1'b0);
    beat(5, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(res_valid), 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    chk("t7_rst_ready", 64'(in_ready), 64'(1));
    chk("t7_rst_res", 64'(res), 64'(0));
    chk("t7_rst_beats", 64'(res_beats), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    beat(3, 3, 1'b1);
    wait_done();
    chk("t7_after_rst_res", 64'(res), 64'(6));
    chk("t7_after_rst_beats", 64'(res_beats), 64'(1));
    tick();
    consume();

    // Randomized traffic, checked every cycle by the model comparator
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = IN_SIZE'($urandom);
      in_b      = IN_SIZE'($urandom);
      in_last   = ($urandom_range(0, 11) == 0);
      clear     = ($urandom_range(0, 59) == 0);
      res_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    clear = 1'b0;
    res_ready = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
